// File: rtl/fifo_axis_pkg.sv
// Shared types and constants for the FIFO-to-AXI4-Stream drain stage.
//   fifo_axis_state_t : drain FSM states (IDLE, RUN, STOP)
//   BUF_DEPTH         : entries in the registered output buffer
//   OCC_W             : width of the buffer occupancy count
package fifo_axis_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } fifo_axis_state_t;

  localparam int unsigned BUF_DEPTH = 2;
  localparam int unsigned OCC_W     = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/axis_skid_buf2.sv
// Two-entry registered buffer in front of an AXI4-Stream master port.
// Entry 0 (the head) drives m_tdata/m_tlast directly; entry 1 holds the
// overflow word while the head is stalled.
//   clk, rst          : clock, asynchronous active-low reset
//   push, push_data,
//   push_last         : write one word into the tail (caller keeps occ<2)
//   occ               : current number of valid entries (0..2)
//   m_tdata, m_tvalid,
//   m_tlast, m_tready : AXI4-Stream master side
module axis_skid_buf2
  import fifo_axis_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_last,
  output logic [OCC_W-1:0]  occ,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  output logic              m_tlast,
  input  logic              m_tready
);

  logic [DATA_W-1:0] tail_data;
  logic              tail_last;
  logic              drain;

  assign m_tvalid = (occ != '0);
  assign drain    = m_tvalid && m_tready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ       <= '0;
      m_tdata   <= '0;
      m_tlast   <= 1'b0;
      tail_data <= '0;
      tail_last <= 1'b0;
    end else begin
      case ({push, drain})
        2'b10: begin
          if (occ == '0) begin
            m_tdata <= push_data;
            m_tlast <= push_last;
          end else begin
            tail_data <= push_data;
            tail_last <= push_last;
          end
          occ <= occ + OCC_W'(1);
        end
        2'b01: begin
          m_tdata <= tail_data;
          m_tlast <= tail_last;
          occ     <= occ - OCC_W'(1);
        end
        2'b11: begin
          // Occupancy unchanged: the incoming word lands wherever the
          // drained head leaves the first free slot.
          if (occ == OCC_W'(1)) begin
            m_tdata <= push_data;
            m_tlast <= push_last;
          end else begin
            m_tdata   <= tail_data;
            m_tlast   <= tail_last;
            tail_data <= push_data;
            tail_last <= push_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_to_axis.sv
// Drains the bridge's outbound FIFO into an AXI4-Stream master, cutting the
// stream into packets of pkt_len words (0 treated as 1) with TLAST on the
// last beat. fifo_rena depends only on registers and fifo_empty; the output
// buffer absorbs m_tready so there is no combinational ready path upstream.
//   clk, rst                 : clock, asynchronous active-low reset
//   enable                   : run request (level)
//   pkt_len                  : words per packet, sampled at each packet start
//   fifo_rdata, fifo_empty   : show-ahead FIFO head and empty flag
//   fifo_rena                : FIFO pop strobe
//   m_tdata, m_tvalid,
//   m_tlast, m_tready        : AXI4-Stream master
//   busy                     : FSM active or buffer holding data
//   pkt_count                : packets completed (TLAST handshakes), wraps
module fifo_to_axis
  import fifo_axis_pkg::*;
#(
  parameter int unsigned C_DATA_WIDTH = 32,
  parameter int unsigned LEN_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [LEN_W-1:0]        pkt_len,
  input  logic [C_DATA_WIDTH-1:0] fifo_rdata,
  input  logic                    fifo_empty,
  output logic                    fifo_rena,
  output logic [C_DATA_WIDTH-1:0] m_tdata,
  output logic                    m_tvalid,
  output logic                    m_tlast,
  input  logic                    m_tready,
  output logic                    busy,
  output logic [LEN_W-1:0]        pkt_count
);

  fifo_axis_state_t state, state_nxt;
  logic [LEN_W-1:0] beat, beat_nxt;
  logic [LEN_W-1:0] len_lat;
  logic [LEN_W-1:0] eff_len;
  logic             last;
  logic [OCC_W-1:0] occ;

  always_comb begin
    eff_len   = len_lat;
    if (beat == '0) begin
      eff_len = (pkt_len == '0) ? LEN_W'(1) : pkt_len;
    end
    last      = (beat == (eff_len - LEN_W'(1)));
    fifo_rena = (state != IDLE) && !fifo_empty && (occ < OCC_W'(BUF_DEPTH));

    beat_nxt = beat;
    if (fifo_rena) begin
      beat_nxt = last ? '0 : beat + LEN_W'(1);
    end

    state_nxt = state;
    case (state)
      IDLE: if (enable) state_nxt = RUN;
      // Decided on the post-pop beat count so a pop in the same cycle that
      // enable falls cannot strand a half-sent packet in IDLE.
      RUN:  if (!enable) state_nxt = (beat_nxt != '0) ? STOP : IDLE;
      STOP: if (fifo_rena && last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      beat      <= '0;
      len_lat   <= LEN_W'(1);
      pkt_count <= '0;
    end else begin
      state <= state_nxt;
      beat  <= beat_nxt;
      if (fifo_rena && (beat == '0)) begin
        len_lat <= eff_len;
      end
      if (m_tvalid && m_tready && m_tlast) begin
        pkt_count <= pkt_count + LEN_W'(1);
      end
    end
  end

  assign busy = (state != IDLE) || (occ != '0);

  axis_skid_buf2 #(
    .DATA_W (C_DATA_WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_rena),
    .push_data (fifo_rdata),
    .push_last (last),
    .occ       (occ),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tlast   (m_tlast),
    .m_tready  (m_tready)
  );

endmodule
